// File: rtl/gfsk_modulator.sv
// GFSK modulator: bytes in over valid/ready, LSB-first NRZ symbols, 3-tap Gaussian
// shaping at SPS samples/symbol, continuous-phase output. IQ outputs with GFSK_MODULATOR_IQ_EN.
module gfsk_modulator #(
  parameter int SPS = 8,
  parameter int DEV = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_en,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  input  logic               tx_last,
  output logic               tx_ready,
  output logic signed [15:0] mod_freq,
  output logic [15:0]        mod_phase,
  output logic               mod_valid,
  output logic               tx_busy,
  output logic               underrun
`ifdef GFSK_MODULATOR_IQ_EN
  ,
  output logic signed [7:0]  mod_i,
  output logic signed [7:0]  mod_q
`endif
);

  localparam int CW = $clog2(SPS);
  localparam logic [CW-1:0] LAST_SAMP = CW'(SPS - 1);
  localparam logic signed [15:0] DEV_W = 16'(DEV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshake: a byte transfers on any clock edge where tx_valid && tx_ready.
  // tx_ready only reflects an empty holding register; it never depends on tx_valid.
  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_valid;

  logic [7:0]          shift_byte;
  logic                shift_last;
  logic [2:0]          bit_idx;
  logic [CW-1:0]       samp_cnt;
  logic                tail_idx;
  logic signed [1:0]   s_old, s_mid, s_new;

  logic                strobe, sym_start, sym_wrap;
  logic                byte_end, tail_end;
  logic                load_idle, load_next, starve;
  logic signed [1:0]   push_sym;
  logic signed [1:0]   o_n, m_n, n_n;
  logic signed [15:0]  tap_sum;
  logic signed [15:0]  shaped;
  logic [15:0]         phase_next;

  function automatic logic signed [15:0] ext(input logic signed [1:0] v);
    return {{14{v[1]}}, v};
  endfunction

  assign tx_ready  = rst_n & ~hold_valid;
  assign strobe    = sample_en && (state != IDLE);
  assign sym_start = (samp_cnt == '0);
  assign sym_wrap  = (samp_cnt == LAST_SAMP);
  assign byte_end  = (state == SHIFT) && strobe && sym_wrap && (bit_idx == 3'd7);
  assign tail_end  = (state == TAIL) && strobe && sym_wrap && tail_idx;
  assign load_idle = (state == IDLE) && hold_valid;
  assign load_next = byte_end && !shift_last && hold_valid;
  assign starve    = byte_end && !shift_last && !hold_valid;

  // Symbol line after this strobe; the emitted sample uses the freshly pushed symbol.
  always_comb begin
    push_sym = 2'sd0;
    if (state == SHIFT) push_sym = shift_byte[bit_idx] ? 2'sd1 : -2'sd1;
    o_n = s_old;
    m_n = s_mid;
    n_n = s_new;
    if (strobe && sym_start) begin
      o_n = s_mid;
      m_n = s_new;
      n_n = push_sym;
    end
    tap_sum    = ext(o_n) + (ext(m_n) <<< 1) + ext(n_n);
    shaped     = (tap_sum * DEV_W) >>> 2;
    phase_next = mod_phase + shaped;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (hold_valid) state_next = SHIFT;
      SHIFT: if (byte_end) state_next = (shift_last || !hold_valid) ? TAIL : SHIFT;
      TAIL:  if (tail_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (load_idle || load_next) begin
      hold_valid <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_data  <= tx_data;
      hold_last  <= tx_last;
      hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_byte <= '0;
      shift_last <= 1'b0;
      bit_idx    <= '0;
      samp_cnt   <= '0;
      tail_idx   <= 1'b0;
      s_old      <= '0;
      s_mid      <= '0;
      s_new      <= '0;
    end else begin
      if (load_idle || load_next) begin
        shift_byte <= hold_data;
        shift_last <= hold_last;
      end
      if (load_idle) begin
        bit_idx  <= '0;
        samp_cnt <= '0;
        s_old    <= '0;
        s_mid    <= '0;
        s_new    <= '0;
      end else if (strobe) begin
        samp_cnt <= sym_wrap ? '0 : samp_cnt + CW'(1);
        s_old    <= o_n;
        s_mid    <= m_n;
        s_new    <= n_n;
        if (state == SHIFT && sym_wrap) bit_idx <= bit_idx + 3'd1;
      end
      // tail_idx selects the second of the two zero-symbol tail periods
      if (state != TAIL)            tail_idx <= 1'b0;
      else if (strobe && sym_wrap)  tail_idx <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_freq  <= '0;
      mod_phase <= '0;
      mod_valid <= 1'b0;
      tx_busy   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      mod_valid <= strobe;
      tx_busy   <= (state_next != IDLE);
      underrun  <= starve;
      if (strobe) begin
        mod_freq  <= shaped;
        mod_phase <= phase_next;
      end else if (state == IDLE) begin
        mod_freq  <= '0;
      end
    end
  end

`ifdef GFSK_MODULATOR_IQ_EN
  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..63; k = 64 folds to 127.
  localparam logic [6:0] SINE_ROM [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  function automatic logic signed [7:0] sine(input logic [7:0] p);
    logic [6:0] k;
    logic [6:0] mag;
    k   = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = k[6] ? 7'd127 : SINE_ROM[k[5:0]];
    return p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mod_i <= '0;
      mod_q <= '0;
    end else if (strobe) begin
      mod_i <= sine(phase_next[15:8] + 8'd64);
      mod_q <= sine(phase_next[15:8]);
    end
  end
`endif

endmodule
